// File: rtl/teclado_varredura_pkg.sv
// Shared types and constants for the 4x3 keypad scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: row/column counts, codes for '*' and '#', FSM and frame-result
// enums, and the row/column -> key code map.
package teclado_pkg;

    localparam int NUM_LINHAS  = 4;
    localparam int NUM_COLUNAS = 3;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    typedef enum logic [1:0] {
        OCIOSO,
        CONFIRMA,
        PRESSIONADA
    } estado_t;

    typedef enum logic [1:0] {
        NENHUMA,
        UNICA,
        MULTIPLA
    } resultado_t;

    // Rows 0..2 hold digits 1..9 laid out left to right; the bottom row is * 0 #.
    function automatic logic [3:0] mapa_tecla(input logic [1:0] linha, input logic [1:0] coluna);
        logic [3:0] codigo;
        if (linha == 2'd3) begin
            case (coluna)
                2'd0:    codigo = KEY_STAR;
                2'd1:    codigo = 4'd0;
                default: codigo = KEY_HASH;
            endcase
        end else begin
            codigo = ({2'b00, linha} * 4'd3) + {2'b00, coluna} + 4'd1;
        end
        return codigo;
    endfunction

endpackage

// File: rtl/teclado_varredura_if.sv
// Keypad-side and controller-side signal bundle of the scanner.
// Latency: n/a (wiring only).
// Backpressure: none; insere is a fire-and-forget strobe.
// Ports: linhas (rows in, active-low), colunas (one-cold column drive),
// numero (last accepted code), insere (1-cycle strobe), tecla_ativa (key held).
interface teclado_varredura_if;
    import teclado_pkg::*;

    logic [NUM_LINHAS-1:0]  linhas;
    logic [NUM_COLUNAS-1:0] colunas;
    logic [3:0]             numero;
    logic                   insere;
    logic                   tecla_ativa;

    // master: the scanner itself.
    modport master (
        input  linhas,
        output colunas,
        output numero,
        output insere,
        output tecla_ativa
    );

    // slave: the keypad/controller environment.
    modport slave (
        output linhas,
        input  colunas,
        input  numero,
        input  insere,
        input  tecla_ativa
    );

endinterface

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
// Latency: 2 clk cycles.
// Backpressure: none.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronised).
// Resets to all-ones so idle keypad rows (pulled high) read as released.
module sincronizador_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/teclado_varredura.sv
// 4x3 matrix keypad scanner with debouncing; one insere strobe per physical press.
// Latency: strobe one cycle after the frame end of the DEBOUNCE-th stable frame.
// Backpressure: none; the consumer must take numero while insere is high.
// Ports: clk, reset (async active-low), bus (teclado_varredura_if.master):
// linhas in, colunas/numero/insere/tecla_ativa out.
module teclado_varredura
    import teclado_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    teclado_varredura_if.master   bus
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);

    localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_C   = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_UM  = CW'(1);

    // ------------------------------------------------------------------
    // Row synchroniser
    // ------------------------------------------------------------------
    logic [NUM_LINHAS-1:0] linhas_s;

    sincronizador_2ff #(
        .WIDTH (NUM_LINHAS)
    ) u_sinc (
        .clk   (clk),
        .rst_n (reset),
        .d     (bus.linhas),
        .q     (linhas_s)
    );

    // ------------------------------------------------------------------
    // Column scan: divider and column index
    // ------------------------------------------------------------------
    logic [DW-1:0] div_q;
    logic [1:0]    col_q;
    logic          amostra;
    logic          fim_quadro;

    // Sample at the last cycle of the slot so the synchronised rows have
    // settled after the column change.
    assign amostra    = (div_q == DIV_MAX);
    assign fim_quadro = amostra && (col_q == 2'd2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
            col_q <= 2'd0;
        end else if (amostra) begin
            div_q <= '0;
            col_q <= (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    logic [NUM_COLUNAS-1:0] colunas_c;

    always_comb begin
        colunas_c = 3'b111;
        case (col_q)
            2'd0:    colunas_c = 3'b110;
            2'd1:    colunas_c = 3'b101;
            default: colunas_c = 3'b011;
        endcase
    end

    assign bus.colunas = colunas_c;

    // ------------------------------------------------------------------
    // Per-sample row decode and per-frame accumulation
    // ------------------------------------------------------------------
    logic [2:0] n_baixas;
    logic [1:0] linha_idx;
    logic [3:0] tecla_agora;

    always_comb begin
        n_baixas  = 3'd0;
        linha_idx = 2'd0;
        for (int r = 0; r < NUM_LINHAS; r++) begin
            if (!linhas_s[r]) begin
                n_baixas  = n_baixas + 3'd1;
                linha_idx = 2'(r);
            end
        end
        tecla_agora = mapa_tecla(linha_idx, col_q);
    end

    // acc_q counts intersections seen so far in this frame, saturating at 2
    // (anything beyond one is already MULTIPLA).
    logic [1:0] acc_q;
    logic [3:0] acc_tecla_q;
    logic [2:0] soma;

    assign soma = {1'b0, acc_q} + n_baixas;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q       <= 2'd0;
            acc_tecla_q <= 4'd0;
        end else if (amostra) begin
            if (fim_quadro) begin
                acc_q <= 2'd0;
            end else begin
                acc_q <= (soma >= 3'd2) ? 2'd2 : soma[1:0];
            end
            if ((acc_q == 2'd0) && (n_baixas == 3'd1)) begin
                acc_tecla_q <= tecla_agora;
            end
        end
    end

    // Result of the frame closing in this cycle (only meaningful on fim_quadro).
    resultado_t resultado;
    logic [3:0] tecla_quadro;

    always_comb begin
        resultado = MULTIPLA;
        if (soma == 3'd0) begin
            resultado = NENHUMA;
        end else if (soma == 3'd1) begin
            resultado = UNICA;
        end
        // The single hit was either in an earlier column or in this one.
        tecla_quadro = (acc_q == 2'd1) ? acc_tecla_q : tecla_agora;
    end

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    estado_t        estado_q, estado_d;
    logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [3:0]     cand_q, cand_d;
    logic [3:0]     numero_q, numero_d;
    logic           insere_q, insere_d;
    logic           ativa_q, ativa_d;

    assign cnt_inc = (cnt_q == DEB_C) ? cnt_q : cnt_q + CNT_UM;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q <= OCIOSO;
            cnt_q    <= '0;
            cand_q   <= 4'd0;
            numero_q <= 4'd0;
            insere_q <= 1'b0;
            ativa_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            numero_q <= numero_d;
            insere_q <= insere_d;
            ativa_q  <= ativa_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        numero_d = numero_q;
        insere_d = 1'b0;
        ativa_d  = ativa_q;

        if (fim_quadro) begin
            unique case (estado_q)
                OCIOSO: begin
                    if (resultado == UNICA) begin
                        cand_d = tecla_quadro;
                        cnt_d  = CNT_UM;
                        if (DEBOUNCE == 1) begin
                            insere_d = 1'b1;
                            numero_d = tecla_quadro;
                            ativa_d  = 1'b1;
                            cnt_d    = '0;
                            estado_d = PRESSIONADA;
                        end else begin
                            estado_d = CONFIRMA;
                        end
                    end
                end
                CONFIRMA: begin
                    if ((resultado == UNICA) && (tecla_quadro == cand_q)) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB_C) begin
                            insere_d = 1'b1;
                            numero_d = cand_q;
                            ativa_d  = 1'b1;
                            cnt_d    = '0;
                            estado_d = PRESSIONADA;
                        end
                    end else begin
                        cnt_d    = '0;
                        estado_d = OCIOSO;
                    end
                end
                PRESSIONADA: begin
                    // Only a run of empty frames releases; a second key or a
                    // slide keeps the press active and restarts the count.
                    if (resultado == NENHUMA) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB_C) begin
                            ativa_d  = 1'b0;
                            cnt_d    = '0;
                            estado_d = OCIOSO;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    cnt_d    = '0;
                    estado_d = OCIOSO;
                end
            endcase
        end
    end

    assign bus.numero      = numero_q;
    assign bus.insere      = insere_q;
    assign bus.tecla_ativa = ativa_q;

endmodule

// File: tb/tb_teclado_varredura.sv
// Directed bench for teclado_varredura with a behavioural keypad and a
// scoreboard queue of expected key codes.
// Parameters: SCAN_DIV=4, DEBOUNCE=2 (12-cycle frames).
module tb_teclado_varredura;
    import teclado_pkg::*;

    localparam int SD = 4;
    localparam int DB = 2;
    localparam int FR = 3 * SD;

    // Bit index of each key in the pressed mask: row*3 + column.
    localparam int K1 = 0;
    localparam int K2 = 1;
    localparam int K4 = 3;
    localparam int K5 = 4;
    localparam int K8 = 7;
    localparam int K9 = 8;
    localparam int KSTAR = 9;
    localparam int K0 = 10;
    localparam int KHASH = 11;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    teclado_varredura_if bus ();

    teclado_varredura #(
        .SCAN_DIV (SD),
        .DEBOUNCE (DB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural keypad: a held key pulls its row low while its column is driven.
    logic [11:0] pressed;
    logic [3:0]  lin;

    always_comb begin
        lin = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!bus.colunas[c] && pressed[r*3 + c]) begin
                    lin[r] = 1'b0;
                end
            end
        end
        bus.linhas = lin;
    end

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [3:0] fila[$];
    logic prev_ins = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest pending expected code
    // and must be exactly one cycle wide.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.insere === 1'b1) begin
            pulses++;
            chk("insere_width", {31'd0, prev_ins}, 32'd0);
            chk("pulse_expected", (fila.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (fila.size() != 0) begin
                chk("numero", {28'd0, bus.numero}, {28'd0, fila.pop_front()});
            end
        end
        prev_ins = bus.insere;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tecla(input int idx, input logic [3:0] code);
        fila.push_back(code);
        pressed[idx] = 1'b1;
        wait_cyc(4 * FR);
        pressed = '0;
        wait_cyc(4 * FR);
    endtask

    initial begin
        pressed = '0;
        reset   = 1'b0;
        wait_cyc(3);
        chk("rst_colunas", {29'd0, bus.colunas}, 32'b110);
        chk("rst_numero", {28'd0, bus.numero}, 32'd0);
        chk("rst_insere", {31'd0, bus.insere}, 32'd0);
        chk("rst_ativa", {31'd0, bus.tecla_ativa}, 32'd0);
        reset = 1'b1;

        // 1: mid-scan reset with a key held
        pressed[K5] = 1'b1;
        wait_cyc(6);
        reset = 1'b0;
        #1;
        chk("mid_rst_colunas", {29'd0, bus.colunas}, 32'b110);
        chk("mid_rst_numero", {28'd0, bus.numero}, 32'd0);
        chk("mid_rst_insere", {31'd0, bus.insere}, 32'd0);
        chk("mid_rst_ativa", {31'd0, bus.tecla_ativa}, 32'd0);
        pressed = '0;
        wait_cyc(2);
        reset = 1'b1;
        wait_cyc(3);
        chk("restart_col0", {29'd0, bus.colunas}, 32'b110);
        wait_cyc(1);
        chk("restart_col1", {29'd0, bus.colunas}, 32'b101);
        wait_cyc(2 * FR);

        // 2: hold '5' for 10 frames, then release
        fila.push_back(4'd5);
        pressed[K5] = 1'b1;
        wait_cyc(10 * FR);
        chk("hold5_ativa", {31'd0, bus.tecla_ativa}, 32'd1);
        pressed = '0;
        wait_cyc(4 * FR);
        chk("rel5_ativa", {31'd0, bus.tecla_ativa}, 32'd0);
        chk("rel5_numero_held", {28'd0, bus.numero}, 32'd5);

        // 3: '8' bouncing on alternate frames, then stable
        for (int i = 0; i < 6; i++) begin
            pressed[K8] = ~pressed[K8];
            wait_cyc(FR);
        end
        chk("bounce_ativa", {31'd0, bus.tecla_ativa}, 32'd0);
        tecla(K8, 4'd8);

        // 4: '1' and '9' together, then release '9'
        pressed[K1] = 1'b1;
        pressed[K9] = 1'b1;
        wait_cyc(5 * FR);
        chk("multi_ativa", {31'd0, bus.tecla_ativa}, 32'd0);
        fila.push_back(4'd1);
        pressed[K9] = 1'b0;
        wait_cyc(4 * FR);
        chk("one_left_ativa", {31'd0, bus.tecla_ativa}, 32'd1);
        pressed = '0;
        wait_cyc(4 * FR);

        // 5: bottom row
        tecla(KSTAR, KEY_STAR);
        tecla(K0, 4'd0);
        tecla(KHASH, KEY_HASH);

        // 6: sequence 5,8,9,2,0,4 with '2' added while '9' is held
        tecla(K5, 4'd5);
        tecla(K8, 4'd8);
        fila.push_back(4'd9);
        pressed[K9] = 1'b1;
        wait_cyc(4 * FR);
        pressed[K2] = 1'b1;
        wait_cyc(3 * FR);
        chk("nine_two_ativa", {31'd0, bus.tecla_ativa}, 32'd1);
        pressed = '0;
        wait_cyc(4 * FR);
        tecla(K2, 4'd2);
        tecla(K0, 4'd0);
        tecla(K4, 4'd4);

        wait_cyc(2 * FR);
        chk("queue_drained", fila.size(), 32'd0);
        chk("pulse_count", pulses, 32'd12);
        chk("end_ativa", {31'd0, bus.tecla_ativa}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
